// File: rtl/motion_uart_tx.sv
// UART 8N1/8N2 transmitter for the motion detector result byte; one frame per tx_start rising edge.
// Optional even parity bit between D7 and STOP when MOTION_TX_PARITY_EN is defined.
module motion_uart_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef MOTION_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            start_q, start_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            edge_s;
  logic            baud_last_s;
  logic [2:0]      nxt_idx_s;

  assign edge_s      = tx_start & ~start_q;
  assign baud_last_s = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign nxt_idx_s   = bit_idx_q + 3'd1;

  // Next-state and next-output logic; the byte is indexed, not shifted, so parity can use it whole.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    start_d    = tx_start;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (edge_s) begin
          shreg_d    = tx_data;
          state_d    = S_START;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_d    = '0;
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef MOTION_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shreg_q;
`else
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
`endif
          end else begin
            bit_idx_d = nxt_idx_s;
            tx_d      = shreg_q[nxt_idx_s];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`ifdef MOTION_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last_s) begin
          baud_d     = '0;
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last_s) begin
          baud_d = '0;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
      end
    endcase
  end

  // State and output registers; start_q resets high so a request already held at reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shreg_q    <= 8'h00;
      start_q    <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_motion_uart_tx.sv
// Bench for motion_uart_tx: a frame-level line model (queue of expected line levels) checked every
// cycle, plus literal checks of bit positions and tx_done timing.
module tb_motion_uart_tx;
  localparam int CLKS = 4;
`ifdef MOTION_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;
  logic       start2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       tx2, busy2, done2;

  int total = 0;
  int bad   = 0;
  bit q[$];
  bit m_prev = 1'b1;
  bit m_done = 1'b0;
  bit logv[0:255];

  motion_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done));

  motion_uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_start(start2), .tx_data(data2),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected line levels of a whole frame, each bit held CLKS cycles.
  task automatic push_frame(input logic [7:0] d);
    bit lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (PB == 1) lv.push_back(^d);
    lv.push_back(1'b1);
    foreach (lv[k]) for (int c = 0; c < CLKS; c++) q.push_back(lv[k]);
  endtask

  task automatic model_step();
    bit was_idle;
    if (rst) begin
      q.delete();
      m_prev = 1'b1;
      m_done = 1'b0;
    end else begin
      was_idle = (q.size() == 0);
      m_done = 1'b0;
      if (!was_idle) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
      if (was_idle && tx_start && !m_prev) push_frame(tx_data);
      m_prev = tx_start;
    end
  endtask

  task automatic tick();
    int etx;
    @(negedge clk);
    model_step();
    etx = (q.size() > 0) ? int'(q[0]) : 1;
    check("tx_line", int'(tx), etx);
    check("tx_busy", int'(tx_busy), (q.size() > 0) ? 1 : 0);
    check("tx_done", int'(tx_done), int'(m_done));
  endtask

  task automatic run_until_done(output int n);
    n = 0;
    while (!tx_done && n < 200) begin
      tick();
      n++;
      logv[n] = tx;
    end
  endtask

  task automatic capture(input logic [7:0] d, input string name);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    logv[0] = tx;
    check(name, int'(tx), 0);
  endtask

  int n, cnt, cnt2;

  initial begin
    // Case 1: plain frame 0x02
    repeat (3) tick();
    rst = 1'b0;
    tick();
    capture(8'h02, "c1_start_bit");
    run_until_done(n);
    check("c1_done_cycle", n, 40 + 4 * PB);
    check("c1_start_mid", int'(logv[2]), 0);
    check("c1_d0", int'(logv[5]), 0);
    check("c1_d1", int'(logv[9]), 1);
    check("c1_d2", int'(logv[13]), 0);
    check("c1_d7", int'(logv[33]), 0);
    check("c1_after_d7", int'(logv[38]), 1);

    // Case 2: tx_start held high across reset release
    tx_data = 8'h01;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_busy) cnt++;
      if (!tx) cnt2++;
    end
    check("c2_busy_cycles", cnt, 0);
    check("c2_tx_low_cycles", cnt2, 0);

    // Case 3: edge while busy is dropped
    tx_start = 1'b0;
    tick();
    capture(8'h01, "c3_start_bit");
    n = 0;
    while (!tx_done && n < 200) begin
      if (n == 12) tx_start = 1'b0;
      if (n == 14) begin tx_start = 1'b1; tx_data = 8'h03; end
      tick();
      n++;
      logv[n] = tx;
    end
    check("c3_done_cycle", n, 40 + 4 * PB);
    check("c3_d0", int'(logv[5]), 1);
    check("c3_d1", int'(logv[9]), 0);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done) cnt++;
      if (tx_busy) cnt2++;
    end
    check("c3_extra_done", cnt, 0);
    check("c3_extra_busy", cnt2, 0);

    // Case 4: edge lands in the tx_done cycle
    tx_start = 1'b0;
    tick();
    capture(8'h01, "c4_start_bit1");
    n = 0;
    while (!tx_done && n < 200) begin
      if (n == 20) tx_start = 1'b0;
      tick();
      n++;
    end
    check("c4_done1_cycle", n, 40 + 4 * PB);
    tx_data  = 8'h03;
    tx_start = 1'b1;
    tick();
    check("c4_b2b_start_bit", int'(tx), 0);
    check("c4_b2b_busy", int'(tx_busy), 1);
    logv[0] = tx;
    run_until_done(n);
    check("c4_done2_cycle", n, 40 + 4 * PB);
    check("c4_d0", int'(logv[5]), 1);
    check("c4_d1", int'(logv[9]), 1);
    check("c4_d2", int'(logv[13]), 0);

    // Case 5: reset during D4 of 0xFF aborts the frame
    tx_start = 1'b0;
    tick();
    capture(8'hFF, "c5_start_bit");
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    check("c5_rst_tx", int'(tx), 1);
    check("c5_rst_busy", int'(tx_busy), 0);
    rst = 1'b0;
    tx_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done) cnt++;
    end
    check("c5_no_done", cnt, 0);
    capture(8'h55, "c5_restart_bit");
    run_until_done(n);
    check("c5_done_cycle", n, 40 + 4 * PB);
    check("c5_d0", int'(logv[5]), 1);
    check("c5_d1", int'(logv[9]), 0);

    // Zero byte goes out like any other
    tx_start = 1'b0;
    tick();
    capture(8'h00, "c7_start_bit");
    run_until_done(n);
    check("c7_done_cycle", n, 40 + 4 * PB);
    check("c7_d3", int'(logv[17]), 0);

`ifdef MOTION_TX_PARITY_EN
    // Case 6: parity bit values
    tx_start = 1'b0;
    tick();
    capture(8'h03, "c6_start_bit_a");
    run_until_done(n);
    check("c6_done_a", n, 44);
    check("c6_parity_a", int'(logv[38]), 0);
    tx_start = 1'b0;
    tick();
    capture(8'h01, "c6_start_bit_b");
    run_until_done(n);
    check("c6_done_b", n, 44);
    check("c6_parity_b", int'(logv[38]), 1);
`endif

    // Two stop bits on the second instance
    data2  = 8'h02;
    start2 = 1'b1;
    tick();
    check("s2_start_bit", int'(tx2), 0);
    n = 0; cnt = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
      if (n == 41 + 4 * PB && tx2) cnt++;
      if (n == 9 && tx2) cnt++;
    end
    check("s2_done_cycle", n, 44 + 4 * PB);
    check("s2_d1_and_stop2", cnt, 2);
    check("s2_busy_after", int'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
